// File: rtl/wb_regfile_if.sv
// Bus bundle for the multithreaded writeback register file: writeback, issue and read ports.
// The master modport drives the request fields; the slave modport is the register file.
interface wb_regfile_if #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int THREAD_BITS        = 2
);
    logic [DATAPATH_WIDTH-1:0]     mem_data_in;
    logic [DATAPATH_WIDTH-1:0]     accum_in;
    logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in;
    logic                          WR_en_in;
    logic                          mem_reg_sel_in;
    logic [THREAD_BITS-1:0]        thread_id_in;
    logic [THREAD_BITS-1:0]        rd_thread_id;
    logic [REGFILE_ADDR_WIDTH-1:0] rA_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] rB_addr;
    logic [DATAPATH_WIDTH-1:0]     rA_data;
    logic [DATAPATH_WIDTH-1:0]     rB_data;
    logic                          issue_en;
    logic [THREAD_BITS-1:0]        issue_thread_id;
    logic [REGFILE_ADDR_WIDTH-1:0] issue_addr;
    logic                          busy_A;
    logic                          busy_B;
    logic [DATAPATH_WIDTH-1:0]     wb_data;

    modport master (
        output mem_data_in, accum_in, WR_addr_in, WR_en_in, mem_reg_sel_in, thread_id_in,
               rd_thread_id, rA_addr, rB_addr, issue_en, issue_thread_id, issue_addr,
        input  rA_data, rB_data, busy_A, busy_B, wb_data
    );

    modport slave (
        input  mem_data_in, accum_in, WR_addr_in, WR_en_in, mem_reg_sel_in, thread_id_in,
               rd_thread_id, rA_addr, rB_addr, issue_en, issue_thread_id, issue_addr,
        output rA_data, rB_data, busy_A, busy_B, wb_data
    );
endinterface

// File: rtl/wb_regfile.sv
// Per-thread register file with same-cycle writeback bypass and a pending-write scoreboard.
// Index 0 of every thread is hardwired to zero and can never be marked pending.
module wb_regfile #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int THREAD_BITS        = 2
) (
    input  logic          clk,
    input  logic          reset,
    wb_regfile_if.slave   bus
);
    localparam int NT = 1 << THREAD_BITS;
    localparam int NR = 1 << REGFILE_ADDR_WIDTH;

    logic [DATAPATH_WIDTH-1:0] r_regs [NT][NR];
    logic [NT-1:0][NR-1:0]     r_sb;

    logic [DATAPATH_WIDTH-1:0] w_wb;
    logic                      w_hit_a;
    logic                      w_hit_b;

    assign w_wb        = bus.mem_reg_sel_in ? bus.mem_data_in : bus.accum_in;
    assign bus.wb_data = w_wb;

    // A same-cycle writeback to the register being read forwards its data and retires its pending bit.
    assign w_hit_a = bus.WR_en_in && (bus.thread_id_in == bus.rd_thread_id) &&
                     (bus.WR_addr_in == bus.rA_addr) && (bus.rA_addr != '0);
    assign w_hit_b = bus.WR_en_in && (bus.thread_id_in == bus.rd_thread_id) &&
                     (bus.WR_addr_in == bus.rB_addr) && (bus.rB_addr != '0);

    assign bus.rA_data = (bus.rA_addr == '0) ? '0 :
                         w_hit_a ? w_wb : r_regs[bus.rd_thread_id][bus.rA_addr];
    assign bus.rB_data = (bus.rB_addr == '0) ? '0 :
                         w_hit_b ? w_wb : r_regs[bus.rd_thread_id][bus.rB_addr];

    assign bus.busy_A = r_sb[bus.rd_thread_id][bus.rA_addr] & ~w_hit_a;
    assign bus.busy_B = r_sb[bus.rd_thread_id][bus.rB_addr] & ~w_hit_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NT; t++)
                for (int r = 0; r < NR; r++)
                    r_regs[t][r] <= '0;
        end else if (bus.WR_en_in && (bus.WR_addr_in != '0)) begin
            r_regs[bus.thread_id_in][bus.WR_addr_in] <= w_wb;
        end
    end

    // Set is ordered after clear so a new issue wins over a retiring writeback to the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb <= '0;
        end else begin
            if (bus.WR_en_in)
                r_sb[bus.thread_id_in][bus.WR_addr_in] <= 1'b0;
            if (bus.issue_en && (bus.issue_addr != '0))
                r_sb[bus.issue_thread_id][bus.issue_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomised + directed bench: driver pushes expected outputs, a negedge monitor pops and compares.
module tb_wb_regfile;
    localparam int W  = 64;
    localparam int AW = 5;
    localparam int TB = 2;
    localparam int NT = 4;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATAPATH_WIDTH(W), .REGFILE_ADDR_WIDTH(AW), .THREAD_BITS(TB)) bus ();

    wb_regfile #(.DATAPATH_WIDTH(W), .REGFILE_ADDR_WIDTH(AW), .THREAD_BITS(TB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] wb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ba;
        logic         bb;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference state: architectural register contents and pending-write flags.
    logic [W-1:0] m_reg  [NT][NR];
    bit           m_pend [NT][NR];

    function automatic logic [W-1:0] f_wb();
        return bus.mem_reg_sel_in ? bus.mem_data_in : bus.accum_in;
    endfunction

    function automatic bit f_fwd(input int a);
        return bus.WR_en_in && int'(bus.thread_id_in) == int'(bus.rd_thread_id) &&
               int'(bus.WR_addr_in) == a && a != 0;
    endfunction

    function automatic logic [W-1:0] f_read(input int a);
        if (a == 0) return '0;
        if (f_fwd(a)) return f_wb();
        return m_reg[bus.rd_thread_id][a];
    endfunction

    function automatic logic f_busy(input int a);
        return m_pend[bus.rd_thread_id][a] && !f_fwd(a);
    endfunction

    // One clock: optionally predict outputs for the current inputs, then advance the model at the edge.
    task automatic step(input string tag, input bit chk);
        exp_t e;
        if (chk) begin
            e.wb = f_wb();
            e.ra = f_read(int'(bus.rA_addr));
            e.rb = f_read(int'(bus.rB_addr));
            e.ba = f_busy(int'(bus.rA_addr));
            e.bb = f_busy(int'(bus.rB_addr));
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        if (reset) begin
            for (int t = 0; t < NT; t++)
                for (int r = 0; r < NR; r++) begin
                    m_reg[t][r]  = '0;
                    m_pend[t][r] = 1'b0;
                end
        end else begin
            if (bus.WR_en_in && bus.WR_addr_in != 0)
                m_reg[bus.thread_id_in][bus.WR_addr_in] = f_wb();
            if (bus.WR_en_in)
                m_pend[bus.thread_id_in][bus.WR_addr_in] = 1'b0;
            if (bus.issue_en && bus.issue_addr != 0)
                m_pend[bus.issue_thread_id][bus.issue_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset              = 1'b0;
        bus.WR_en_in       = 1'b0;
        bus.issue_en       = 1'b0;
        bus.mem_reg_sel_in = 1'b0;
        bus.mem_data_in    = '0;
        bus.accum_in       = '0;
        bus.WR_addr_in     = '0;
        bus.thread_id_in   = '0;
        bus.issue_addr     = '0;
        bus.issue_thread_id = '0;
        bus.rd_thread_id   = '0;
        bus.rA_addr        = '0;
        bus.rB_addr        = '0;
    endtask

    task automatic chk1(input string tag, input string fld, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
        end
    endtask

    // Monitor: combinational outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            chk1(tg, "wb_data", bus.wb_data, e.wb);
            chk1(tg, "rA_data", bus.rA_data, e.ra);
            chk1(tg, "rB_data", bus.rB_data, e.rb);
            chk1(tg, "busy_A", {{(W-1){1'b0}}, bus.busy_A}, {{(W-1){1'b0}}, e.ba});
            chk1(tg, "busy_B", {{(W-1){1'b0}}, bus.busy_B}, {{(W-1){1'b0}}, e.bb});
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        #1;
        step("reset", 1'b0);
        idle();

        // Everything reads zero and idle after reset.
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < NR; a++) begin
                bus.rd_thread_id = TB'(t);
                bus.rA_addr      = AW'(a);
                bus.rB_addr      = AW'(NR - 1 - a);
                step("reset_sweep", 1'b1);
            end

        // Bypass then storage, other thread untouched.
        idle();
        bus.WR_en_in = 1'b1; bus.thread_id_in = 2'd2; bus.WR_addr_in = 5'd5;
        bus.mem_reg_sel_in = 1'b1; bus.mem_data_in = 64'hDEAD_BEEF; bus.accum_in = 64'h5555;
        bus.rd_thread_id = 2'd2; bus.rA_addr = 5'd5; bus.rB_addr = 5'd5;
        step("bypass", 1'b1);
        bus.WR_en_in = 1'b0;
        step("stored", 1'b1);
        bus.rd_thread_id = 2'd1;
        step("other_thread", 1'b1);

        // Index 0 is never written and never pending.
        idle();
        bus.WR_en_in = 1'b1; bus.WR_addr_in = 5'd0; bus.accum_in = 64'h1234;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
        step("zero_write", 1'b1);
        idle();
        step("zero_after", 1'b1);

        // Issue marks pending, writeback retires it in the same cycle.
        idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
        step("issue7", 1'b1);
        idle(); bus.rA_addr = 5'd7; bus.rB_addr = 5'd7;
        step("pend7", 1'b1);
        bus.WR_en_in = 1'b1; bus.WR_addr_in = 5'd7; bus.accum_in = 64'hA5A5;
        step("retire7", 1'b1);
        bus.WR_en_in = 1'b0;
        step("clear7", 1'b1);

        // Simultaneous issue and writeback on the same bit: stays pending, value stored.
        idle();
        bus.issue_en = 1'b1; bus.issue_thread_id = 2'd3; bus.issue_addr = 5'd9;
        bus.WR_en_in = 1'b1; bus.thread_id_in = 2'd3; bus.WR_addr_in = 5'd9; bus.accum_in = 64'hCAFE_F00D;
        step("set_clr9", 1'b1);
        idle(); bus.rd_thread_id = 2'd3; bus.rA_addr = 5'd9; bus.rB_addr = 5'd9;
        step("after9", 1'b1);

        // Reset overrides a same-cycle write and issue.
        idle();
        bus.issue_en = 1'b1; bus.issue_thread_id = 2'd1; bus.issue_addr = 5'd3;
        step("pre_rst_issue", 1'b1);
        idle();
        reset = 1'b1;
        bus.WR_en_in = 1'b1; bus.thread_id_in = 2'd1; bus.WR_addr_in = 5'd3; bus.accum_in = 64'hFF;
        bus.issue_en = 1'b1; bus.issue_thread_id = 2'd1; bus.issue_addr = 5'd4;
        bus.rd_thread_id = 2'd1; bus.rA_addr = 5'd3; bus.rB_addr = 5'd4;
        step("rst_wr", 1'b1);
        idle(); bus.rd_thread_id = 2'd1; bus.rA_addr = 5'd3; bus.rB_addr = 5'd4;
        step("rst_after", 1'b1);

        // Random traffic, addresses biased low so collisions are frequent.
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 99) == 0);
            bus.WR_en_in       = $urandom_range(0, 1);
            bus.issue_en       = $urandom_range(0, 1);
            bus.mem_reg_sel_in = $urandom_range(0, 1);
            bus.mem_data_in    = {$urandom, $urandom};
            bus.accum_in       = {$urandom, $urandom};
            bus.thread_id_in   = TB'($urandom);
            bus.issue_thread_id = TB'($urandom);
            bus.rd_thread_id   = TB'($urandom);
            bus.WR_addr_in     = AW'($urandom_range(0, 7));
            bus.issue_addr     = AW'($urandom_range(0, 7));
            bus.rA_addr        = AW'($urandom_range(0, 7));
            bus.rB_addr        = ($urandom_range(0, 3) == 0) ? bus.rA_addr : AW'($urandom);
            step("random", 1'b1);
        end

        idle();
        repeat (2) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
